// File: rtl/irda_pkg.sv
// rtl/irda_pkg.sv - shared types, constants and helpers for the IrDA SIR transmitter
package irda_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } irda_state_e;

  localparam int TICKS_PER_BIT = 16;

  // Even parity over up to 9 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/irda_baud_gen.sv
// rtl/irda_baud_gen.sv - clock divider and 16x sub-bit tick counter for the IrDA transmitter
module irda_baud_gen
  import irda_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clear,
  output logic [3:0] tick_idx,
  output logic       tick_end,
  output logic       bit_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tick_q, tick_d;

  assign tick_idx = tick_q;
  assign tick_end = (div_q == DIV_MAX);
  assign bit_end  = tick_end && (tick_q == 4'(TICKS_PER_BIT - 1));

  always_comb begin
    div_d  = div_q;
    tick_d = tick_q;
    if (ena) begin
      if (clear) begin
        div_d  = '0;
        tick_d = '0;
      end else if (tick_end) begin
        div_d  = '0;
        tick_d = tick_q + 4'd1;
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/irda_tx_engine.sv
// rtl/irda_tx_engine.sv - IrDA SIR transmit engine: framing FSM, shifter, parity and RZ pulse shaper
module irda_tx_engine
  import irda_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 27,
  parameter int PULSE_TICKS = 3,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              ir_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 4);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W + PARITY_EN + STOP_BITS);

  irda_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ir_q, ir_d;

  logic [3:0] tick_idx, tick_nxt;
  logic       tick_end, bit_end, accept, frame_end;

  irda_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .clear    (accept),
    .tick_idx (tick_idx),
    .tick_end (tick_end),
    .bit_end  (bit_end)
  );

  // The bit counter runs across the whole frame, so its value identifies the last stop bit.
  assign frame_end = (state_q == STOP) && bit_end && (bit_q == LAST_BIT);
  assign done      = ena && !rst && frame_end;
  assign tx_ready  = ena && !rst && ((state_q == IDLE) || frame_end);
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != IDLE);
  assign tx_out    = tx_q;
  assign ir_out    = ir_q;

  // Tick index the baud generator will hold next cycle, so ir_out can be registered in step with tx_out.
  assign tick_nxt = accept ? 4'd0 : (tick_end ? tick_idx + 4'd1 : tick_idx);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    if (accept) begin
      state_d = START;
      shift_d = tx_data;
      bit_d   = '0;
      par_d   = even_parity(9'(tx_data)) ^ (PARITY_ODD != 0);
    end else if (ena && bit_end) begin
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = bit_q + CNT_W'(1);
        end
        DATA: begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + CNT_W'(1);
          if (bit_q == LAST_DATA) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          state_d = STOP;
          bit_d   = bit_q + CNT_W'(1);
        end
        STOP: begin
          if (bit_q == LAST_BIT) state_d = IDLE;
          else                   bit_d   = bit_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    ir_d = !tx_d && (tick_nxt < 4'(PULSE_TICKS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ir_q    <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_irda_tx_engine.sv
// tb/tb_irda_tx_engine.sv - scoreboard bench for irda_tx_engine over three configurations
module tb_irda_tx_engine;

  typedef struct {
    int          lat;
    logic [15:0] bits;
    int          nbits;
    int          pulses;
    int          width;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v, ena_v, valid_v;
  logic [7:0] data_v [3];
  logic [2:0] ready_w, tx_out_w, ir_out_w, busy_w, done_w;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  irda_tx_engine #(.CLK_DIV(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .ena(ena_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_w[0]), .tx_out(tx_out_w[0]), .ir_out(ir_out_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  irda_tx_engine #(.CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst_v[1]), .ena(ena_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_w[1]), .tx_out(tx_out_w[1]), .ir_out(ir_out_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  irda_tx_engine #(.CLK_DIV(4), .PULSE_TICKS(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .ena(ena_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_w[2]), .tx_out(tx_out_w[2]), .ir_out(ir_out_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  function automatic int div_of(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic exp_t mk(input int lat, input logic [15:0] bits, input int nbits,
                              input int pulses, input int width);
    exp_t e;
    e.lat = lat; e.bits = bits; e.nbits = nbits; e.pulses = pulses; e.width = width;
    return e;
  endfunction

  function automatic int qsize(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 in the cycle after the accept.
  task automatic send(input int k, input logic [7:0] d, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    valid_v[k] = 1'b1;
    data_v[k]  = d;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (ready_w[k]) begin
        ok = 1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    valid_v[k] = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (qsize(k) == 0 && !busy_w[k]) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("done_timeout", 32'(qsize(k)), 32'd0);
  endtask

  // Monitor state, one slot per DUT
  logic        active_m [3];
  logic        ena_prev_m [3];
  logic        irp_m [3];
  logic [15:0] bits_m [3];
  int          t0_m [3], pos_m [3], nb_m [3], npulse_m [3];
  int          wmin_m [3], wmax_m [3], curw_m [3], misal_m [3];
  int          tp_m;
  exp_t        e_m;

  initial begin
    for (int k = 0; k < 3; k++) begin
      active_m[k] = 0; ena_prev_m[k] = 0; irp_m[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_v[k]) begin
          active_m[k] = 0;
        end else begin
          // A new bit position appears only after a cycle in which ena was high.
          if (active_m[k] && ena_prev_m[k]) begin
            pos_m[k]++;
            tp_m = (pos_m[k] - 1) % (16 * div_of(k));
            if (tp_m == 8 * div_of(k) && nb_m[k] < 16) begin
              bits_m[k][nb_m[k]] = tx_out_w[k];
              nb_m[k]++;
            end
            if (ir_out_w[k]) begin
              if (!irp_m[k]) begin
                npulse_m[k]++;
                curw_m[k] = 1;
                if (tp_m != 0) misal_m[k]++;
              end else begin
                curw_m[k]++;
              end
            end else if (irp_m[k]) begin
              if (curw_m[k] < wmin_m[k]) wmin_m[k] = curw_m[k];
              if (curw_m[k] > wmax_m[k]) wmax_m[k] = curw_m[k];
            end
            irp_m[k] = ir_out_w[k];
          end
          if (done_w[k]) begin
            if (qsize(k) == 0 || !active_m[k]) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done dut%0d: got done=1 expected none (cycle %0d)", k, cyc);
            end else begin
              if (k == 0) e_m = q0.pop_front();
              else if (k == 1) e_m = q1.pop_front();
              else e_m = q2.pop_front();
              chk($sformatf("dut%0d done_latency", k), 32'(cyc - t0_m[k]), 32'(e_m.lat));
              chk($sformatf("dut%0d nbits", k), 32'(nb_m[k]), 32'(e_m.nbits));
              chk($sformatf("dut%0d tx_bits", k), {16'd0, bits_m[k]}, {16'd0, e_m.bits});
              chk($sformatf("dut%0d ir_pulses", k), 32'(npulse_m[k]), 32'(e_m.pulses));
              chk($sformatf("dut%0d ir_wmin", k), 32'(wmin_m[k]), 32'(e_m.width));
              chk($sformatf("dut%0d ir_wmax", k), 32'(wmax_m[k]), 32'(e_m.width));
              chk($sformatf("dut%0d ir_misaligned", k), 32'(misal_m[k]), 32'd0);
            end
            active_m[k] = 0;
          end
          if (valid_v[k] && ready_w[k]) begin
            active_m[k] = 1; t0_m[k] = cyc; pos_m[k] = 0; nb_m[k] = 0; bits_m[k] = '0;
            npulse_m[k] = 0; wmin_m[k] = 999; wmax_m[k] = 0; curw_m[k] = 0; misal_m[k] = 0; irp_m[k] = 0;
          end
        end
        ena_prev_m[k] = ena_v[k];
      end
    end
  end

  initial begin
    int a1, a2;
    bit seen;
    rst_v = '1; ena_v = '1; valid_v = '0;
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;

    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d ready_in_reset", k), 32'(ready_w[k]), 32'd0);
      chk($sformatf("dut%0d reset_tx_out", k), 32'(tx_out_w[k]), 32'd1);
      chk($sformatf("dut%0d reset_ir_out", k), 32'(ir_out_w[k]), 32'd0);
      chk($sformatf("dut%0d reset_busy", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("dut%0d reset_done", k), 32'(done_w[k]), 32'd0);
    end
    rst_v = '0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d ready_after_reset", k), 32'(ready_w[k]), 32'd1);
    @(posedge clk); #1;

    // Basic frame 0x55
    send(0, 8'h55, a1);
    push(0, mk(160, 16'h02AA, 10, 5, 3));
    wait_idle(0);

    // Back-to-back 0xA5 then 0x3C with tx_valid held
    send(0, 8'hA5, a1);
    push(0, mk(160, 16'h034A, 10, 5, 3));
    send(0, 8'h3C, a2);
    push(0, mk(160, 16'h0278, 10, 5, 3));
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd160);
    wait_idle(0);
    @(posedge clk); #1;

    // Stall for 40 cycles inside bit d3 of 0x96, while its IR pulse is high
    send(0, 8'h96, a1);
    push(0, mk(200, 16'h032C, 10, 5, 3));
    repeat (65) begin @(posedge clk); #1; end
    ena_v[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("stall_tx_out", 32'(tx_out_w[0]), 32'd0);
      chk("stall_ir_out", 32'(ir_out_w[0]), 32'd1);
      chk("stall_busy", 32'(busy_w[0]), 32'd1);
      chk("stall_ready", 32'(ready_w[0]), 32'd0);
      @(posedge clk); #1;
    end
    ena_v[0] = 1'b1;
    wait_idle(0);
    @(posedge clk); #1;

    // Reset in the middle of bit 4 of 0x00
    send(0, 8'h00, a1);
    repeat (69) begin @(posedge clk); #1; end
    rst_v[0] = 1'b1;
    #1;
    chk("rst_cycle_ready", 32'(ready_w[0]), 32'd0);
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    #1;
    chk("post_rst_tx_out", 32'(tx_out_w[0]), 32'd1);
    chk("post_rst_ir_out", 32'(ir_out_w[0]), 32'd0);
    chk("post_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("post_rst_ready", 32'(ready_w[0]), 32'd1);
    seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_w[0]) seen = 1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);

    // Odd parity, two stop bits, 0x07
    send(1, 8'h07, a1);
    push(1, mk(192, 16'h0C0E, 12, 7, 3));
    wait_idle(1);

    // Single-tick pulses at CLK_DIV=4, 0x00
    send(2, 8'h00, a1);
    push(2, mk(640, 16'h0200, 10, 9, 4));
    wait_idle(2);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
